// File: rtl/tank_motion.sv
// tank_motion: per-frame tank heading/position controller.
// A synchronised frame strobe starts a four-state update (IDLE, ROTATE, MOVE, LIMIT).
// Positions are unsigned Q10.6. All visible outputs refresh together on the LIMIT cycle.
// Optional macro TANK_WRAP_EN: LIMIT wraps the position around the allowed range
// instead of clamping it to the range edge.
module tank_motion #(
    parameter int X_START    = 320,
    parameter int Y_START    = 240,
    parameter int HEAD_START = 0,
    parameter int SPEED      = 2,
    parameter int ROT_DIV    = 4,
    parameter int X_MIN      = 8,
    parameter int X_MAX      = 631,
    parameter int Y_MIN      = 8,
    parameter int Y_MAX      = 471
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       rot_left,
    input  logic       rot_right,
    input  logic       fwd,
    input  logic       back,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output logic [7:0] sin_out,
    output logic [7:0] cos_out,
    output logic [4:0] heading,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_MOVE, S_LIMIT} state_t;

    localparam logic [3:0] RCNT_LAST = 4'(ROT_DIV - 1);
    localparam logic [4:0] SPEED_S   = 5'(SPEED);

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [3:0]  keys_q, keys_d;        // {rot_left, rot_right, fwd, back}
    logic [3:0]  rcnt_q, rcnt_d;
    logic [4:0]  head_q, head_d;
    logic [15:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [17:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [9:0]  tank_x_q, tank_x_d, tank_y_q, tank_y_d;
    logic [7:0]  sin_q, sin_d, cos_q, cos_d;
    logic [4:0]  heading_q, heading_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        tick;
    logic signed [12:0] dx, dy;
    logic [15:0] lim_x, lim_y;

    // First-quadrant magnitude of round(64*sin(m*11.25 deg)), m = 0..8.
    function automatic logic [7:0] quarter_mag(input logic [3:0] m);
        case (m)
            4'd0:    quarter_mag = 8'd0;
            4'd1:    quarter_mag = 8'd12;
            4'd2:    quarter_mag = 8'd24;
            4'd3:    quarter_mag = 8'd36;
            4'd4:    quarter_mag = 8'd45;
            4'd5:    quarter_mag = 8'd53;
            4'd6:    quarter_mag = 8'd59;
            4'd7:    quarter_mag = 8'd63;
            default: quarter_mag = 8'd64;
        endcase
    endfunction

    // Full 32-entry signed sine folded from the quarter table.
    function automatic logic [7:0] sin_tab(input logic [4:0] k);
        logic [3:0] m;
        logic [7:0] mag;
        m   = k[3] ? (4'd8 - {1'b0, k[2:0]}) : {1'b0, k[2:0]};
        mag = quarter_mag(m);
        sin_tab = k[4] ? (8'd0 - mag) : mag;
    endfunction

    // Bring an 18-bit signed sum back into [mn, mx] integer pixels.
    function automatic logic [15:0] limit_axis(input logic [17:0] s, input int mn, input int mx);
        logic signed [11:0] ip;
        logic signed [11:0] mn_s;
        logic signed [11:0] mx_s;
        ip   = s[17:6];
        mn_s = 12'(mn);
        mx_s = 12'(mx);
`ifdef TANK_WRAP_EN
        if (ip < mn_s)
            limit_axis = 16'(s + 18'((mx - mn + 1) << 6));
        else if (ip > mx_s)
            limit_axis = 16'(s - 18'((mx - mn + 1) << 6));
        else
            limit_axis = s[15:0];
`else
        if (ip < mn_s)
            limit_axis = {10'(mn), 6'b0};
        else if (ip > mx_s)
            limit_axis = {10'(mx), 6'b0};
        else
            limit_axis = s[15:0];
`endif
    endfunction

    assign tick  = sync_q[1] & ~sync_q[2];
    assign lim_x = limit_axis(sum_x_q, X_MIN, X_MAX);
    assign lim_y = limit_axis(sum_y_q, Y_MIN, Y_MAX);

    // Per-frame displacement along the current heading, Q.6 units.
    always_comb begin
        dx = 13'($signed(sin_tab(head_q + 5'd8))) * 13'($signed(SPEED_S));
        dy = 13'($signed(sin_tab(head_q))) * 13'($signed(SPEED_S));
    end

    // Next-state logic for the synchroniser, update FSM and output registers.
    always_comb begin
        sync_d    = {sync_q[1:0], frame_clk};
        state_d   = state_q;
        keys_d    = keys_q;
        rcnt_d    = rcnt_q;
        head_d    = head_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        tank_x_d  = tank_x_q;
        tank_y_d  = tank_y_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        heading_d = heading_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    keys_d  = {rot_left, rot_right, fwd, back};
                    state_d = S_ROTATE;
                end
            end
            S_ROTATE: begin
                if (keys_q[3] ^ keys_q[2]) begin
                    if (rcnt_q == 4'd0)
                        head_d = keys_q[2] ? (head_q + 5'd1) : (head_q - 5'd1);
                    rcnt_d = (rcnt_q >= RCNT_LAST) ? 4'd0 : (rcnt_q + 4'd1);
                end else begin
                    rcnt_d = 4'd0;
                end
                state_d = S_MOVE;
            end
            S_MOVE: begin
                sum_x_d = {2'b00, pos_x_q};
                sum_y_d = {2'b00, pos_y_q};
                if (keys_q[1] & ~keys_q[0]) begin
                    sum_x_d = 18'($signed({2'b00, pos_x_q}) + 18'(dx));
                    sum_y_d = 18'($signed({2'b00, pos_y_q}) + 18'(dy));
                end else if (~keys_q[1] & keys_q[0]) begin
                    sum_x_d = 18'($signed({2'b00, pos_x_q}) - 18'(dx));
                    sum_y_d = 18'($signed({2'b00, pos_y_q}) - 18'(dy));
                end
                state_d = S_LIMIT;
            end
            S_LIMIT: begin
                pos_x_d   = lim_x;
                pos_y_d   = lim_y;
                tank_x_d  = lim_x[15:6];
                tank_y_d  = lim_y[15:6];
                sin_d     = sin_tab(head_q);
                cos_d     = sin_tab(head_q + 5'd8);
                heading_d = head_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any partial update.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            sync_q    <= 3'b000;
            keys_q    <= 4'b0000;
            rcnt_q    <= 4'd0;
            head_q    <= 5'(HEAD_START);
            pos_x_q   <= {10'(X_START), 6'b0};
            pos_y_q   <= {10'(Y_START), 6'b0};
            sum_x_q   <= 18'd0;
            sum_y_q   <= 18'd0;
            tank_x_q  <= 10'(X_START);
            tank_y_q  <= 10'(Y_START);
            sin_q     <= sin_tab(5'(HEAD_START));
            cos_q     <= sin_tab(5'(HEAD_START + 8));
            heading_q <= 5'(HEAD_START);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            keys_q    <= keys_d;
            rcnt_q    <= rcnt_d;
            head_q    <= head_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            tank_x_q  <= tank_x_d;
            tank_y_q  <= tank_y_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            heading_q <= heading_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign TankX      = tank_x_q;
    assign TankY      = tank_y_q;
    assign sin_out    = sin_q;
    assign cos_out    = cos_q;
    assign heading    = heading_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
